lfsr_bist_engine: RTL and testbench
===================================

LFSR_BIST_ENGINE -- requirements
Module: lfsr_bist_engine

Interface
REQ-001 SHALL have parameter N_CHAINS, default 7: scan-chain count; also the TPG and MISR width (2..32).
REQ-002 SHALL have parameter CHAIN_LEN, default 32: shift cycles per pattern (>=1).
REQ-003 SHALL have parameter N_PATTERNS, default 127: patterns applied per run (>=1).
REQ-004 SHALL have parameters TPG_TAPS (default 7'h41, x^7+x^6+1), TPG_SEED (default 7'h01), MISR_TAPS (default 7'h41) and GOLDEN_SIG (default 0), each N_CHAINS wide.
REQ-005 SHALL have port CK, input, 1: the single clock, rising edge.
REQ-006 SHALL have port BIST_reset_n, input, 1: the reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1: single-cycle run request, honoured only in IDLE or DONE.
REQ-008 SHALL have port abort, input, 1: return to IDLE.
REQ-009 SHALL have port SO_chain, input, N_CHAINS: scan-chain outputs from the CUT.
REQ-010 SHALL have port SI_chain, output, N_CHAINS: scan-chain inputs, equal to the TPG state.
REQ-011 SHALL have port scan_en, output, 1: shift enable to the CUT.
REQ-012 SHALL have ports busy, done and pass, outputs, 1 each, plus port signature, output, N_CHAINS: the MISR state.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT, CAPTURE, UNLOAD and DONE.
REQ-014 SHALL step both LFSRs in Galois form: next = {q[N-2:0],1'b0} ^ (q[N-1] ? TAPS : 0) ^ din; din is 0 for the TPG and SO_chain for the MISR.
REQ-015 SHALL, when start is seen in IDLE or DONE, load TPG := TPG_SEED (1 if the seed is 0), clear MISR, clear the counters, clear done and pass, and enter SHIFT on the next cycle.
REQ-016 SHALL, in SHIFT, drive scan_en=1 and SI_chain=TPG, advance the TPG every cycle, and leave SHIFT after CHAIN_LEN cycles for CAPTURE.
REQ-017 SHALL, in CAPTURE, run exactly 1 cycle with scan_en=0, TPG and MISR holding, and increment the pattern count; it then goes to SHIFT if patterns < N_PATTERNS, else to UNLOAD.
REQ-018 SHALL keep the MISR disabled during pattern 0 SHIFT (chain contents unknown) and compact during SHIFT of patterns >=1 and during UNLOAD.
REQ-019 SHALL, in UNLOAD, run CHAIN_LEN cycles with scan_en=1 and the TPG still advancing, then enter DONE.
REQ-020 SHALL, on entry to DONE, register pass=(MISR==GOLDEN_SIG) and set done=1; done, pass and signature then hold until the next start or reset.
REQ-021 SHALL make the run length exactly N_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN cycles from the first SHIFT cycle to done rising.
REQ-022 SHALL keep busy=1 in every state except IDLE and DONE.
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL make abort win over start: abort in any state goes to IDLE next cycle with scan_en=0 and done=0, and pass is cleared.
REQ-025 SHALL use counters of width $clog2(max+1) that never wrap during a legal run.

Reset
REQ-026 SHALL force, while BIST_reset_n=0: state=IDLE, TPG=0, MISR=0, counters=0, SI_chain=0, scan_en=0, busy=0, done=0, pass=0, signature=0.
REQ-027 SHALL treat reset mid-run as equivalent to abort, with all state cleared.

Structure
REQ-028 SHALL put the state enum, default tap/seed constants and the Galois step function in package bist_pkg.
REQ-029 SHALL use one sub-module, lfsr_par (params WIDTH, TAPS; ports CK, BIST_reset_n, load, seed, en, din, q), instantiated twice: TPG with din=0, MISR with din=SO_chain.

Verification
REQ-030 SHALL cover: reset, then start with defaults -> SI_chain sequence 01,02,04,08,10,20,40,41,43 on consecutive SHIFT cycles, and scan_en=1.
REQ-031 SHALL cover: CHAIN_LEN=4, N_PATTERNS=2 -> scan_en pattern 1111 0 1111 0 1111, and done rises exactly 14 cycles after the first SHIFT.
REQ-032 SHALL cover: SO_chain tied 0, GOLDEN_SIG=0 -> pass=1; the same run with one SO bit flipped in pattern 1 -> pass=0 and signature!=0.
REQ-033 SHALL cover: abort during pattern 1 SHIFT -> IDLE next cycle with busy=0 and done=0; a following start re-runs from seed 01.
REQ-034 SHALL cover: BIST_reset_n pulsed low mid-UNLOAD -> all outputs 0 immediately, with no clock required.
REQ-035 SHALL cover: start pulsed while busy -> no effect on the cycle count; start in DONE -> done clears and a new run begins.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and helpers for the LFSR-based logic BIST engine:
// FSM state encoding, default polynomial/seed constants and the Galois LFSR step.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } bist_state_e;

  // x^7 + x^6 + 1, maximal-length for the default 7-chain configuration
  localparam logic [31:0] DEF_TPG_TAPS  = 32'h0000_0041;
  localparam logic [31:0] DEF_TPG_SEED  = 32'h0000_0001;
  localparam logic [31:0] DEF_MISR_TAPS = 32'h0000_0041;

  // One Galois step on the low 'width' bits; bits above width are forced to 0.
  function automatic logic [31:0] galois_step(input logic [31:0] q,
                                              input logic [31:0] taps,
                                              input logic [31:0] din,
                                              input int unsigned width);
    logic [31:0] mask;
    logic        msb;
    mask = (32'd1 << width) - 32'd1;
    msb  = |(q & (32'd1 << (width - 32'd1)));
    return ((q << 1) ^ (msb ? taps : 32'd0) ^ din) & mask;
  endfunction

endpackage

// File: rtl/lfsr_par.sv
// Parallel-input Galois LFSR: used as the pattern generator (din = 0)
// and as the multiple-input signature register (din = scan-chain outputs).
module lfsr_par
  import bist_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TPG_TAPS)
) (
  input  logic             CK,
  input  logic             BIST_reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  assign w_next = WIDTH'(galois_step(32'(r_q), 32'(TAPS), 32'(din), WIDTH));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CK or negedge BIST_reset_n) begin
    if (!BIST_reset_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= seed;
    end else if (en) begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/lfsr_bist_engine.sv
// Logic BIST controller: drives scan chains from a TPG LFSR, compacts the
// responses in a MISR and compares the final signature against a golden value.
module lfsr_bist_engine
  import bist_pkg::*;
#(
  parameter int                  N_CHAINS   = 7,
  parameter int                  CHAIN_LEN  = 32,
  parameter int                  N_PATTERNS = 127,
  parameter logic [N_CHAINS-1:0] TPG_TAPS   = N_CHAINS'(DEF_TPG_TAPS),
  parameter logic [N_CHAINS-1:0] TPG_SEED   = N_CHAINS'(DEF_TPG_SEED),
  parameter logic [N_CHAINS-1:0] MISR_TAPS  = N_CHAINS'(DEF_MISR_TAPS),
  parameter logic [N_CHAINS-1:0] GOLDEN_SIG = '0
) (
  input  logic                CK,
  input  logic                BIST_reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [N_CHAINS-1:0] SO_chain,
  output logic [N_CHAINS-1:0] SI_chain,
  output logic                scan_en,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_CHAINS-1:0] signature
);

  localparam int SC_W = $clog2(CHAIN_LEN + 1);
  localparam int PC_W = $clog2(N_PATTERNS + 1);
  localparam logic [SC_W-1:0]     SHIFT_LAST = SC_W'(CHAIN_LEN - 1);
  localparam logic [PC_W-1:0]     PAT_LAST   = PC_W'(N_PATTERNS - 1);
  // An all-zero seed would lock the TPG at zero forever
  localparam logic [N_CHAINS-1:0] SEED_EFF   = (TPG_SEED == '0) ? N_CHAINS'(1) : TPG_SEED;

  bist_state_e r_state, w_next_state;

  logic [SC_W-1:0]     r_shift_cnt;
  logic [PC_W-1:0]     r_pat_cnt;
  logic                r_done;
  logic                r_pass;
  logic                w_go;
  logic                w_shift_last;
  logic                w_pat_last;
  logic                w_tpg_en;
  logic                w_misr_en;
  logic [N_CHAINS-1:0] w_tpg_q;
  logic [N_CHAINS-1:0] w_misr_q;
  logic [N_CHAINS-1:0] w_misr_next;

  assign w_go         = start && !abort && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_shift_last = (r_shift_cnt == SHIFT_LAST);
  assign w_pat_last   = (r_pat_cnt == PAT_LAST);
  assign w_misr_next  = N_CHAINS'(galois_step(32'(w_misr_q), 32'(MISR_TAPS),
                                              32'(SO_chain), N_CHAINS));

  // NOTE: state, TPG and MISR are all plain flops, so the async reset clears
  // every bit of run state without needing a clock.
  always_ff @(posedge CK or negedge BIST_reset_n) begin
    if (!BIST_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave a latch behind.
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: if (start) w_next_state = ST_SHIFT;
        ST_SHIFT:         if (w_shift_last) w_next_state = ST_CAPTURE;
        ST_CAPTURE:       w_next_state = w_pat_last ? ST_UNLOAD : ST_SHIFT;
        ST_UNLOAD:        if (w_shift_last) w_next_state = ST_DONE;
        default:          w_next_state = ST_IDLE;
      endcase
    end
  end

  // Pattern 0 fills the chains from an unknown state, so it is not compacted
  always_comb begin
    scan_en   = 1'b0;
    busy      = 1'b0;
    w_tpg_en  = 1'b0;
    w_misr_en = 1'b0;
    unique case (r_state)
      ST_SHIFT: begin
        scan_en   = 1'b1;
        busy      = 1'b1;
        w_tpg_en  = !abort;
        w_misr_en = !abort && (r_pat_cnt != '0);
      end
      ST_CAPTURE: busy = 1'b1;
      ST_UNLOAD: begin
        scan_en   = 1'b1;
        busy      = 1'b1;
        w_tpg_en  = !abort;
        w_misr_en = !abort;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CK or negedge BIST_reset_n) begin
    if (!BIST_reset_n) begin
      r_shift_cnt <= '0;
      r_pat_cnt   <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else if (abort || w_go) begin
      r_shift_cnt <= '0;
      r_pat_cnt   <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_SHIFT, ST_UNLOAD: begin
          r_shift_cnt <= w_shift_last ? '0 : r_shift_cnt + 1'b1;
          if (r_state == ST_UNLOAD && w_shift_last) begin
            // Compare the signature the MISR takes on at this same edge
            r_done <= 1'b1;
            r_pass <= (w_misr_next == GOLDEN_SIG);
          end
        end
        ST_CAPTURE: r_pat_cnt <= r_pat_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  lfsr_par #(
    .WIDTH (N_CHAINS),
    .TAPS  (TPG_TAPS)
  ) u_tpg (
    .CK           (CK),
    .BIST_reset_n (BIST_reset_n),
    .load         (w_go),
    .seed         (SEED_EFF),
    .en           (w_tpg_en),
    .din          ('0),
    .q            (w_tpg_q)
  );

  lfsr_par #(
    .WIDTH (N_CHAINS),
    .TAPS  (MISR_TAPS)
  ) u_misr (
    .CK           (CK),
    .BIST_reset_n (BIST_reset_n),
    .load         (w_go),
    .seed         ('0),
    .en           (w_misr_en),
    .din          (SO_chain),
    .q            (w_misr_q)
  );

  assign SI_chain  = w_tpg_q;
  assign signature = w_misr_q;
  assign done      = r_done;
  assign pass      = r_pass;

endmodule

// File: tb/tb_lfsr_bist_engine.sv
// Scoreboard bench: stimulus pushes hand-computed expectations into queues,
// independent monitor processes pop and compare when the DUTs present results.
module tb_lfsr_bist_engine;

  typedef struct {
    int         cycles;
    logic       pass;
    logic [6:0] sig;
  } done_exp_t;

  logic       CK;
  // default-parameter instance
  logic       rst_def, start_def, abort_def;
  logic [6:0] so_def, si_def, sig_def;
  logic       scan_def, busy_def, done_def, pass_def;
  // CHAIN_LEN=4, N_PATTERNS=2 instance
  logic       rst_sm, start_sm, abort_sm;
  logic [6:0] so_sm, si_sm, sig_sm;
  logic       scan_sm, busy_sm, done_sm, pass_sm;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  q_si_def[$];
  logic [7:0]  q_si_sm[$];
  logic [1:0]  q_restart[$];
  logic [3:0]  q_abort[$];
  logic [17:0] q_rst_def[$];
  logic [17:0] q_rst_sm[$];
  done_exp_t   q_done[$];

  lfsr_bist_engine u_dut_def (
    .CK           (CK),
    .BIST_reset_n (rst_def),
    .start        (start_def),
    .abort        (abort_def),
    .SO_chain     (so_def),
    .SI_chain     (si_def),
    .scan_en      (scan_def),
    .busy         (busy_def),
    .done         (done_def),
    .pass         (pass_def),
    .signature    (sig_def)
  );

  lfsr_bist_engine #(
    .CHAIN_LEN  (4),
    .N_PATTERNS (2)
  ) u_dut_sm (
    .CK           (CK),
    .BIST_reset_n (rst_sm),
    .start        (start_sm),
    .abort        (abort_sm),
    .SO_chain     (so_sm),
    .SI_chain     (si_sm),
    .scan_en      (scan_sm),
    .busy         (busy_sm),
    .done         (done_sm),
    .pass         (pass_sm),
    .signature    (sig_sm)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic wait_done_sm(input string name);
    int k;
    k = 0;
    while (done_sm !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    if (done_sm !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: done not seen within 40 cycles", name);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge CK) begin
    if (busy_def === 1'b1 && q_si_def.size() > 0)
      check("si_def", {24'd0, scan_def, si_def}, {24'd0, q_si_def.pop_front()});
  end

  always @(negedge CK) begin
    if (busy_sm === 1'b1 && q_si_sm.size() > 0)
      check("si_sm", {24'd0, scan_sm, si_sm}, {24'd0, q_si_sm.pop_front()});
  end

  always @(negedge rst_def) begin
    #1;
    if (q_rst_def.size() > 0)
      check("rst_def", {14'd0, si_def, scan_def, busy_def, done_def, pass_def, sig_def},
            {14'd0, q_rst_def.pop_front()});
  end

  always @(negedge rst_sm) begin
    #1;
    if (q_rst_sm.size() > 0)
      check("rst_sm", {14'd0, si_sm, scan_sm, busy_sm, done_sm, pass_sm, sig_sm},
            {14'd0, q_rst_sm.pop_front()});
  end

  logic prev_busy = 1'b0, prev_done = 1'b0, prev_start = 1'b0, prev_abort = 1'b0;
  int   cyc = 0;

  always @(negedge CK) begin
    done_exp_t e;
    if (busy_sm === 1'b1 && prev_busy !== 1'b1) cyc = 0;
    else cyc++;
    if (done_sm === 1'b1 && prev_done !== 1'b1) begin
      if (q_done.size() > 0) begin
        e = q_done.pop_front();
        check("done_cycles", cyc, e.cycles);
        check("done_pass", {31'd0, pass_sm}, {31'd0, e.pass});
        check("done_sig", {25'd0, sig_sm}, {25'd0, e.sig});
      end else begin
        n_checks++;
        n_errors++;
        $display("FAIL done_unexpected: done rose with sig %h, none expected", sig_sm);
      end
    end
    if (prev_start === 1'b1 && prev_done === 1'b1 && q_restart.size() > 0)
      check("restart", {30'd0, busy_sm, done_sm}, {30'd0, q_restart.pop_front()});
    if (prev_abort === 1'b1 && q_abort.size() > 0)
      check("abort", {28'd0, busy_sm, done_sm, scan_sm, pass_sm}, {28'd0, q_abort.pop_front()});
    prev_busy  = busy_sm;
    prev_done  = done_sm;
    prev_start = start_sm;
    prev_abort = abort_sm;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] si_def_tab [9]  = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'hC0, 8'hC1, 8'hC3};
    logic [7:0] si_sm_tab  [14] = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h10, 8'h90, 8'hA0,
                                    8'hC0, 8'hC1, 8'h43, 8'hC3, 8'hC7, 8'hCF, 8'hDF};
    rst_def = 1'b1; start_def = 1'b0; abort_def = 1'b0; so_def = '0;
    rst_sm  = 1'b1; start_sm  = 1'b0; abort_sm  = 1'b0; so_sm  = '0;

    q_rst_def.push_back('0);
    q_rst_sm.push_back('0);
    #2;
    rst_def = 1'b0;
    rst_sm  = 1'b0;
    #20;
    rst_def = 1'b1;
    rst_sm  = 1'b1;

    // Default configuration: first nine SHIFT cycles follow the TPG from seed 01
    foreach (si_def_tab[i]) q_si_def.push_back(si_def_tab[i]);
    tick();
    start_def = 1'b1; tick(); start_def = 1'b0;
    repeat (12) tick();
    abort_def = 1'b1; tick(); abort_def = 1'b0;

    // Run A: clean chains, extra start pulses while busy must not disturb timing
    foreach (si_sm_tab[i]) q_si_sm.push_back(si_sm_tab[i]);
    q_done.push_back('{cycles: 14, pass: 1'b1, sig: 7'h00});
    tick();
    start_sm = 1'b1; tick(); start_sm = 1'b0;
    repeat (3) tick();
    start_sm = 1'b1; tick(); start_sm = 1'b0;
    repeat (4) tick();
    start_sm = 1'b1; tick(); start_sm = 1'b0;
    wait_done_sm("run_a");

    // Run B from DONE: one SO bit flipped on the first pattern-1 shift cycle
    q_restart.push_back(2'b10);
    q_done.push_back('{cycles: 14, pass: 1'b0, sig: 7'h41});
    start_sm = 1'b1; tick(); start_sm = 1'b0;
    repeat (5) tick();
    so_sm = 7'h01; tick(); so_sm = '0;
    wait_done_sm("run_b");

    // Run C from DONE: abort during pattern-1 SHIFT
    q_restart.push_back(2'b10);
    start_sm = 1'b1; tick(); start_sm = 1'b0;
    repeat (6) tick();
    q_abort.push_back(4'b0000);
    abort_sm = 1'b1; tick(); abort_sm = 1'b0;

    // Run D: restarts from seed 01, then reset lands mid-UNLOAD between edges
    tick();
    for (int i = 0; i < 4; i++) q_si_sm.push_back(si_sm_tab[i]);
    start_sm = 1'b1; tick(); start_sm = 1'b0;
    repeat (11) tick();
    q_rst_sm.push_back('0);
    #1;
    rst_sm = 1'b0;
    #6;
    rst_sm = 1'b1;
    repeat (3) tick();

    check("left_si_def", q_si_def.size(), 0);
    check("left_si_sm", q_si_sm.size(), 0);
    check("left_done", q_done.size(), 0);
    check("left_restart", q_restart.size(), 0);
    check("left_abort", q_abort.size(), 0);
    check("left_rst", q_rst_def.size() + q_rst_sm.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
